// File: rtl/inst_fetch.sv
// Instruction fetch stage: keeps the PC, assembles each 32-bit instruction from
// four byte reads, and presents it to IF/ID while honouring stall and branch redirects.
module inst_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        branch_flag,
    input  logic [31:0] branch_target,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic [7:0]  mem_rdata,
    input  logic        mem_rvalid,
    output logic [31:0] if_pc,
    output logic [31:0] if_inst,
    output logic        if_valid
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] FETCH = 2'd1;
    localparam logic [1:0] VALID = 2'd2;

    logic [1:0]  state_r;
    logic [31:0] pc_r;
    logic [1:0]  cnt_r;
    logic [31:0] buf_r;
    logic [31:0] next_buf_s;

    // Merge the incoming byte into its lane; byte at pc+0 lands in the top lane.
    always_comb begin
        next_buf_s = buf_r;
        case (cnt_r)
            2'd0:    next_buf_s[31:24] = mem_rdata;
            2'd1:    next_buf_s[23:16] = mem_rdata;
            2'd2:    next_buf_s[15:8]  = mem_rdata;
            2'd3:    next_buf_s[7:0]   = mem_rdata;
            default: next_buf_s        = buf_r;
        endcase
    end

    assign mem_req  = (state_r == FETCH);
    assign mem_addr = pc_r + {30'd0, cnt_r};

    // Fetch sequencing; a branch overrides stall and any byte delivered that cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= IDLE;
            pc_r     <= RESET_PC;
            cnt_r    <= 2'd0;
            buf_r    <= 32'd0;
            if_valid <= 1'b0;
            if_pc    <= 32'd0;
            if_inst  <= 32'd0;
        end else if (branch_flag) begin
            state_r  <= FETCH;
            pc_r     <= branch_target;
            cnt_r    <= 2'd0;
            buf_r    <= 32'd0;
            if_valid <= 1'b0;
            if_pc    <= 32'd0;
            if_inst  <= 32'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    state_r <= FETCH;
                    cnt_r   <= 2'd0;
                end
                FETCH: begin
                    if (mem_rvalid) begin
                        buf_r <= next_buf_s;
                        if (cnt_r == 2'd3) begin
                            if_valid <= 1'b1;
                            if_pc    <= pc_r;
                            if_inst  <= next_buf_s;
                            pc_r     <= pc_r + 32'd4;
                            cnt_r    <= 2'd0;
                            state_r  <= VALID;
                        end else begin
                            cnt_r <= cnt_r + 2'd1;
                        end
                    end else begin
                        state_r <= FETCH;
                    end
                end
                VALID: begin
                    if (!stall) begin
                        if_valid <= 1'b0;
                        if_pc    <= 32'd0;
                        if_inst  <= 32'd0;
                        state_r  <= FETCH;
                    end else begin
                        state_r <= VALID;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    cnt_r   <= 2'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: reset/wrap vector table, directed corner sequences, and
// randomized traffic checked against a transaction-level reference model.
module tb_inst_fetch;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst, stall, branch_flag, mem_rvalid;
    logic [31:0] branch_target;
    logic [7:0]  mem_rdata;
    logic        mem_req, if_valid;
    logic [31:0] mem_addr, if_pc, if_inst;
    logic        w_mem_req, w_if_valid;
    logic [31:0] w_mem_addr, w_if_pc, w_if_inst;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    inst_fetch #(.RESET_PC(RESET_PC)) dut (
        .clk(clk), .rst(rst), .stall(stall), .branch_flag(branch_flag),
        .branch_target(branch_target), .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid), .if_pc(if_pc),
        .if_inst(if_inst), .if_valid(if_valid)
    );

    inst_fetch #(.RESET_PC(32'hFFFF_FFFE)) u_wrap (
        .clk(clk), .rst(rst), .stall(stall), .branch_flag(branch_flag),
        .branch_target(branch_target), .mem_req(w_mem_req), .mem_addr(w_mem_addr),
        .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid), .if_pc(w_if_pc),
        .if_inst(w_if_inst), .if_valid(w_if_valid)
    );

    // Reference model: mode 0 = waiting after reset, 1 = collecting bytes, 2 = presenting
    int          m_mode = 0;
    bit          m_known = 1'b0;
    logic [31:0] m_pc;
    logic [7:0]  m_q[$];
    logic        m_v;
    logic [31:0] m_opc, m_oinst;

    function automatic logic [7:0] mem_byte(input logic [31:0] a);
        return (a[7:0] ^ 8'hA5) + a[15:8] + a[31:24];
    endfunction

    function automatic logic [31:0] exp_addr();
        return m_pc + 32'(m_q.size());
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic model_edge(input logic r, input logic st, input logic br,
                              input logic [31:0] tgt, input logic rv, input logic [7:0] rd);
        if (r) begin
            m_mode = 0; m_pc = RESET_PC; m_q.delete();
            m_v = 1'b0; m_opc = 32'd0; m_oinst = 32'd0; m_known = 1'b1;
        end else if (!m_known) begin
            m_known = 1'b0;
        end else if (br) begin
            m_mode = 1; m_pc = tgt; m_q.delete();
            m_v = 1'b0; m_opc = 32'd0; m_oinst = 32'd0;
        end else begin
            case (m_mode)
                0: m_mode = 1;
                1: if (rv) begin
                    m_q.push_back(rd);
                    if (m_q.size() == 4) begin
                        m_v = 1'b1; m_opc = m_pc;
                        m_oinst = {m_q[0], m_q[1], m_q[2], m_q[3]};
                        m_pc = m_pc + 32'd4; m_q.delete(); m_mode = 2;
                    end
                end
                2: if (!st) begin
                    m_v = 1'b0; m_opc = 32'd0; m_oinst = 32'd0; m_mode = 1;
                end
                default: m_mode = 0;
            endcase
        end
    endtask

    // Called at the falling edge: compare, drive, step one clock, update model.
    task automatic cycle(input logic r, input logic st, input logic br,
                         input logic [31:0] tgt, input logic rv, input logic [7:0] rd);
        if (m_known) begin
            chk("mem_req",  {31'd0, mem_req},  {31'd0, m_mode == 1});
            chk("mem_addr", mem_addr, exp_addr());
            chk("if_valid", {31'd0, if_valid}, {31'd0, m_v});
            chk("if_pc",    if_pc,   m_opc);
            chk("if_inst",  if_inst, m_oinst);
        end
        rst = r; stall = st; branch_flag = br; branch_target = tgt;
        mem_rvalid = rv; mem_rdata = rd;
        @(posedge clk);
        model_edge(r, st, br, tgt, rv, rd);
        @(negedge clk);
    endtask

    task automatic auto_cycle(input logic r, input logic st, input logic br,
                              input logic [31:0] tgt, input logic rv);
        logic [7:0] rd;
        rd = (rv && m_known) ? mem_byte(exp_addr()) : 8'($urandom);
        cycle(r, st, br, tgt, rv, rd);
    endtask

    typedef struct {
        logic        rv;
        logic [7:0]  rd;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_pc;
        logic [31:0] e_inst;
        logic [31:0] e_waddr;
        logic [31:0] e_wpc;
    } vec_t;

    vec_t tbl[7];

    initial begin
        int edges, wcnt, held;
        logic rv, got;
        logic [31:0] tgt;

        tbl[0] = '{1'b0, 8'h00, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0,         32'hFFFF_FFFE, 32'h0};
        tbl[1] = '{1'b1, 8'h13, 1'b1, 32'h0, 1'b0, 32'h0, 32'h0,         32'hFFFF_FFFE, 32'h0};
        tbl[2] = '{1'b1, 8'h00, 1'b1, 32'h1, 1'b0, 32'h0, 32'h0,         32'hFFFF_FFFF, 32'h0};
        tbl[3] = '{1'b1, 8'h00, 1'b1, 32'h2, 1'b0, 32'h0, 32'h0,         32'h0000_0000, 32'h0};
        tbl[4] = '{1'b1, 8'h00, 1'b1, 32'h3, 1'b0, 32'h0, 32'h0,         32'h0000_0001, 32'h0};
        tbl[5] = '{1'b0, 8'h00, 1'b0, 32'h4, 1'b1, 32'h0, 32'h1300_0000, 32'h0000_0002, 32'hFFFF_FFFE};
        tbl[6] = '{1'b0, 8'h00, 1'b1, 32'h4, 1'b0, 32'h0, 32'h0,         32'h0000_0002, 32'h0};

        rst = 1'b1; stall = 1'b0; branch_flag = 1'b0; branch_target = 32'd0;
        mem_rvalid = 1'b0; mem_rdata = 8'd0;
        @(negedge clk);
        auto_cycle(1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
        auto_cycle(1'b1, 1'b0, 1'b0, 32'd0, 1'b0);

        // Reset release vectors, with the wrap-around instance alongside
        for (int i = 0; i < 7; i++) begin
            chk("tbl_mem_req",  {31'd0, mem_req},  {31'd0, tbl[i].e_req});
            chk("tbl_mem_addr", mem_addr, tbl[i].e_addr);
            chk("tbl_if_valid", {31'd0, if_valid}, {31'd0, tbl[i].e_valid});
            chk("tbl_if_pc",    if_pc,   tbl[i].e_pc);
            chk("tbl_if_inst",  if_inst, tbl[i].e_inst);
            chk("tbl_wrap_req",   {31'd0, w_mem_req},  {31'd0, tbl[i].e_req});
            chk("tbl_wrap_addr",  w_mem_addr, tbl[i].e_waddr);
            chk("tbl_wrap_valid", {31'd0, w_if_valid}, {31'd0, tbl[i].e_valid});
            chk("tbl_wrap_pc",    w_if_pc,   tbl[i].e_wpc);
            chk("tbl_wrap_inst",  w_if_inst, tbl[i].e_inst);
            cycle(1'b0, 1'b0, 1'b0, 32'd0, tbl[i].rv, tbl[i].rd);
        end

        // Two wait cycles before every byte: first if_valid 13 edges after release
        auto_cycle(1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
        edges = 0; wcnt = 0; got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            rv = (m_mode == 1) && (wcnt == 2);
            if (m_mode == 1) wcnt = rv ? 0 : wcnt + 1;
            auto_cycle(1'b0, 1'b0, 1'b0, 32'd0, rv);
            edges++;
            if (if_valid === 1'b1) got = 1'b1;
        end
        chk("wait_latency", 32'(edges), 32'd13);
        chk("wait_inst", if_inst, {mem_byte(32'd0), mem_byte(32'd1), mem_byte(32'd2), mem_byte(32'd3)});

        // Stall for three cycles while VALID: outputs held four cycles, no request
        held = 0;
        for (int i = 0; i < 4; i++) begin
            if (if_valid === 1'b1 && mem_req === 1'b0) held++;
            auto_cycle(1'b0, (i < 3), 1'b0, 32'd0, 1'b1);
        end
        chk("stall_hold", 32'(held), 32'd4);
        chk("post_stall_addr", mem_addr, 32'h4);

        // Branch after two bytes; the byte delivered on the branch edge is dropped
        auto_cycle(1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
        auto_cycle(1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
        auto_cycle(1'b0, 1'b0, 1'b1, 32'h100, 1'b1);
        chk("branch_addr", mem_addr, 32'h100);
        for (int i = 0; i < 10 && if_valid !== 1'b1; i++)
            auto_cycle(1'b0, 1'b1, 1'b0, 32'd0, 1'b1);
        chk("branch_pc", if_pc, 32'h100);
        chk("branch_inst", if_inst,
            {mem_byte(32'h100), mem_byte(32'h101), mem_byte(32'h102), mem_byte(32'h103)});

        // Branch during VALID with stall asserted: branch wins
        auto_cycle(1'b0, 1'b1, 1'b1, 32'h200, 1'b0);
        chk("bv_valid", {31'd0, if_valid}, 32'd0);
        chk("bv_req", {31'd0, mem_req}, 32'd1);
        chk("bv_addr", mem_addr, 32'h200);

        // Reset mid-fetch drops the request on the next cycle
        auto_cycle(1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
        auto_cycle(1'b1, 1'b0, 1'b0, 32'd0, 1'b1);
        chk("rst_req", {31'd0, mem_req}, 32'd0);
        chk("rst_addr", mem_addr, RESET_PC);

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            tgt = $urandom;
            if ($urandom_range(0, 3) == 0) tgt = 32'hFFFF_FFFC + 32'($urandom_range(0, 3));
            auto_cycle(($urandom_range(0, 199) == 0), ($urandom_range(0, 2) == 0),
                       ($urandom_range(0, 19) == 0), tgt, ($urandom_range(0, 3) != 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/inst_fetch.md
# inst_fetch

Instruction fetch stage of the 5-stage CPU. It maintains the PC and reads each 32-bit instruction as four bytes over the 8-bit memory-controller port. It presents the completed instruction and its address to the IF/ID pipeline register, and obeys stall and branch-redirect requests from later stages. While no complete instruction is available it drives an all-zero bubble.

## Interface

- RESET_PC, 32'h0000_0000, PC value loaded on reset
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  reset, synchronous, active-high
- stall  in  1  downstream hazard stall; hold the current instruction
- branch_flag  in  1  redirect request from EX; single-cycle pulse
- branch_target  in  32  new PC, sampled when branch_flag=1
- mem_req  out  1  byte read request
- mem_addr  out  32  byte address of the request
- mem_rdata  in  8  read data; valid when mem_rvalid=1
- mem_rvalid  in  1  completes the request in the same cycle (mem_req & mem_rvalid = byte transferred)
- if_pc  out  32  address of the presented instruction; 0 when if_valid=0
- if_inst  out  32  presented instruction, memory byte order; 0 when if_valid=0
- if_valid  out  1  if_pc/if_inst hold a real instruction

## Operation

- State registers: pc[31:0], cnt[1:0], buf[31:0], state ∈ {IDLE, FETCH, VALID}.
- mem_addr = pc + cnt. The addition is 32-bit and wraps modulo 2^32. mem_req = (state==FETCH), combinational from registers.
- Byte placement: the byte at pc+0 goes to buf[31:24], pc+1 to [23:16], pc+2 to [15:8], pc+3 to [7:0]. Endian swapping is the IF/ID register's job.
- IDLE: entered only from reset. Goes to FETCH on the next edge with cnt=0.
- FETCH, cycle with mem_rvalid=1 and branch_flag=0:
  - Store mem_rdata into the byte lane selected by cnt.
  - If cnt<3: cnt++.
  - If cnt==3: load the if_* outputs (if_pc=pc, if_inst=completed word, if_valid=1), set pc<=pc+4 and cnt<=0, go to VALID.
- FETCH, cycle with mem_rvalid=0: hold all state. mem_req stays high.
- VALID:
  - stall=1: hold the outputs. mem_req=0.
  - stall=0: next edge clears if_valid, if_pc and if_inst to 0 and goes to FETCH for the next PC.
- Stall during FETCH has no effect. Fetch continues; the stall takes effect once VALID is reached.
- Branch priority: branch_flag has priority over stall and over mem_rvalid, in every state. On the edge:
  - pc<=branch_target, cnt<=0, buf<=0.
  - if_valid, if_pc and if_inst are cleared to 0.
  - State goes to FETCH.
  - A byte delivered in that same cycle is discarded.
- The branch target is not alignment-checked. It is fetched exactly as given.
- Memory protocol: only one byte is in flight at a time, and it is completed in its handshake cycle. There are never any outstanding responses to drain.

## Timing

- Reset values: pc=RESET_PC, cnt=0, buf=0, state=IDLE, if_valid=0, if_pc=0, if_inst=0, mem_req=0, mem_addr=RESET_PC.
- rst asserted mid-fetch or mid-VALID: every register returns to its reset value on that edge. The partially fetched word is lost and mem_req drops in the following cycle.
- Zero-wait memory (rvalid=1 whenever req=1), no stall: mem_req is high 4 cycles, then if_valid is high 1 cycle. Throughput is one instruction per 5 cycles.
- First instruction after reset release: mem_req first high 1 cycle after release. if_valid rises 5 edges after release.
- Each wait cycle (rvalid=0) adds exactly one cycle of latency.
- if_* outputs are registered. They change only on clock edges.
- Branch redirect: the first mem_req to branch_target is in the cycle after the branch edge.

## Test plan

- Reset behaviour: reset, then release; memory returns bytes 13,00,00,00 at address 0..3 → mem_addr sequence 0,1,2,3; then if_valid=1, if_pc=0, if_inst=32'h1300_0000 for exactly one cycle; next mem_addr=4.
- Wait states: rvalid low for 2 cycles before each byte → if_valid rises 8 cycles later than zero-wait; instruction value unchanged.
- Stall: stall=1 for 3 cycles while VALID → if_valid/if_pc/if_inst held for 4 cycles, mem_req=0 throughout; fetch of pc+4 starts after stall drops.
- Branch mid-fetch: branch_flag with target 32'h100 after 2 bytes fetched → next mem_addr=32'h100, cnt restarts at 0; the next if_pc=32'h100 with that address's bytes only.
- Branch during VALID together with stall=1 → branch wins; if_valid=0 next cycle; fetch starts at target.
- Wrap-around: RESET_PC=32'hFFFF_FFFE → mem_addr sequence FFFF_FFFE, FFFF_FFFF, 0, 1; next pc=32'h0000_0002.
